// File: rtl/mcpu_core_sb_pkg.sv
// Shared constants and entry-state encoding for the core scoreboard.
// Imported by the per-entry tracker and by the lane decode top level.
package mcpu_core_sb_pkg;

    localparam int LANES      = 4;
    localparam int ALU_LAT    = 2;
    localparam int SB_CNT_W   = $clog2(ALU_LAT + 1);
    localparam int REG_IDX_W  = 5;
    localparam int PRED_IDX_W = 2;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_SHORT = 2'd1,
        SB_LONG  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/mcpu_core_sb_entry.sv
// One scoreboard entry: tracks a single register or predicate producer.
// Short producers count down from ALU_LAT; long producers wait for writeback.
module mcpu_core_sb_entry
    import mcpu_core_sb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic set_long_i,
    input  logic clr_wb_i,
    input  logic flush_i,
    output logic pending_o,
    output logic err_wb_o
);

    sb_state_e             state_q, state_d;
    logic [SB_CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush beats issue; issue beats any clear (writeback or expiry).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_wb_o = 1'b0;
        if (flush_i) begin
            state_d = SB_IDLE;
            cnt_d   = '0;
        end else if (set_i) begin
            state_d = set_long_i ? SB_LONG : SB_SHORT;
            cnt_d   = SB_CNT_W'(ALU_LAT);
        end else begin
            case (state_q)
                SB_SHORT: begin
                    cnt_d = cnt_q - SB_CNT_W'(1);
                    if (cnt_q <= SB_CNT_W'(1)) begin
                        state_d = SB_IDLE;
                        cnt_d   = '0;
                    end
                end
                SB_LONG: begin
                    if (clr_wb_i) begin
                        state_d = SB_IDLE;
                    end
                end
                default: begin
                    state_d = SB_IDLE;
                end
            endcase
        end
        // A writeback only makes sense against a pending long producer.
        if (clr_wb_i && !flush_i && !set_i && (state_q != SB_LONG)) begin
            err_wb_o = 1'b1;
        end
    end

    assign pending_o = (state_q != SB_IDLE);

endmodule

// File: rtl/mcpu_core_scoreboard.sv
// Register/predicate scoreboard for the 4-lane core: decodes issue and
// writeback lanes onto per-entry trackers and exports the pending vectors.
module mcpu_core_scoreboard
    import mcpu_core_sb_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NPREDS = 3
) (
    input  logic                          clkrst_core_clk,
    input  logic                          clkrst_core_rst,
    input  logic [LANES-1:0]              pc2sb_issue_valid,
    input  logic [LANES*REG_IDX_W-1:0]    pc2sb_rd_num,
    input  logic [LANES-1:0]              pc2sb_rd_we,
    input  logic [LANES-1:0]              pc2sb_pred_we,
    input  logic [LANES-1:0]              pc2sb_long,
    input  logic [LANES-1:0]              wb2sb_valid,
    input  logic [LANES*REG_IDX_W-1:0]    wb2sb_rd_num,
    input  logic [LANES-1:0]              wb2sb_is_pred,
    input  logic                          exc2sb_flush,
    output logic [NREGS-1:0]              sb2d_reg_scoreboard,
    output logic [NPREDS-1:0]             sb2d_pred_scoreboard,
    output logic                          sb2d_busy,
    output logic                          sb2exc_err
);

    logic [NREGS-1:0]  reg_set, reg_set_long, reg_wb, reg_pend, reg_err;
    logic [NPREDS-1:0] pred_set, pred_set_long, pred_wb, pred_pend, pred_err;
    logic              err_q, err_d;

    // Predicate index 3 is the constant-true predicate and never matches an entry.
    always_comb begin
        reg_set       = '0;
        reg_set_long  = '0;
        reg_wb        = '0;
        pred_set      = '0;
        pred_set_long = '0;
        pred_wb       = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int r = 0; r < NREGS; r++) begin
                if (pc2sb_issue_valid[l] && pc2sb_rd_we[l] &&
                    (int'(pc2sb_rd_num[l*REG_IDX_W +: REG_IDX_W]) == r)) begin
                    reg_set[r] = 1'b1;
                    if (pc2sb_long[l]) begin
                        reg_set_long[r] = 1'b1;
                    end
                end
                if (wb2sb_valid[l] && !wb2sb_is_pred[l] &&
                    (int'(wb2sb_rd_num[l*REG_IDX_W +: REG_IDX_W]) == r)) begin
                    reg_wb[r] = 1'b1;
                end
            end
            for (int p = 0; p < NPREDS; p++) begin
                if (pc2sb_issue_valid[l] && !pc2sb_rd_we[l] && pc2sb_pred_we[l] &&
                    (int'(pc2sb_rd_num[l*REG_IDX_W +: PRED_IDX_W]) == p)) begin
                    pred_set[p] = 1'b1;
                    if (pc2sb_long[l]) begin
                        pred_set_long[p] = 1'b1;
                    end
                end
                if (wb2sb_valid[l] && wb2sb_is_pred[l] &&
                    (int'(wb2sb_rd_num[l*REG_IDX_W +: PRED_IDX_W]) == p)) begin
                    pred_wb[p] = 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        mcpu_core_sb_entry u_entry (
            .clk_i      (clkrst_core_clk),
            .rst_i      (clkrst_core_rst),
            .set_i      (reg_set[r]),
            .set_long_i (reg_set_long[r]),
            .clr_wb_i   (reg_wb[r]),
            .flush_i    (exc2sb_flush),
            .pending_o  (reg_pend[r]),
            .err_wb_o   (reg_err[r])
        );
    end

    for (genvar p = 0; p < NPREDS; p++) begin : g_pred
        mcpu_core_sb_entry u_entry (
            .clk_i      (clkrst_core_clk),
            .rst_i      (clkrst_core_rst),
            .set_i      (pred_set[p]),
            .set_long_i (pred_set_long[p]),
            .clr_wb_i   (pred_wb[p]),
            .flush_i    (exc2sb_flush),
            .pending_o  (pred_pend[p]),
            .err_wb_o   (pred_err[p])
        );
    end

    assign err_d = ((|reg_err) || (|pred_err)) && !exc2sb_flush;

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sb2d_reg_scoreboard  = reg_pend;
    assign sb2d_pred_scoreboard = pred_pend;
    assign sb2d_busy            = (|reg_pend) || (|pred_pend);
    assign sb2exc_err           = err_q;

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
// Self-checking bench for mcpu_core_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared against a deadline-based model.
module tb_mcpu_core_scoreboard;

    localparam int L   = 4;
    localparam int NR  = 32;
    localparam int NP  = 3;
    localparam int NE  = NR + NP;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [L-1:0]  iv, rd_we, pred_we, lng, wv, wpred;
    logic [L*5-1:0] rd, wrd;
    logic          flush;
    logic [NR-1:0] reg_sb;
    logic [NP-1:0] pred_sb;
    logic          busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcpu_core_scoreboard dut (
        .clkrst_core_clk      (clk),
        .clkrst_core_rst      (rst),
        .pc2sb_issue_valid    (iv),
        .pc2sb_rd_num         (rd),
        .pc2sb_rd_we          (rd_we),
        .pc2sb_pred_we        (pred_we),
        .pc2sb_long           (lng),
        .wb2sb_valid          (wv),
        .wb2sb_rd_num         (wrd),
        .wb2sb_is_pred        (wpred),
        .exc2sb_flush         (flush),
        .sb2d_reg_scoreboard  (reg_sb),
        .sb2d_pred_scoreboard (pred_sb),
        .sb2d_busy            (busy),
        .sb2exc_err           (err)
    );

    // Model: an entry is pending at cycle t if active and (long or t <= due).
    int cyc = 0;
    bit m_act [NE];
    bit m_long[NE];
    int m_due [NE];
    bit m_err;
    bit s_set [NE];
    bit s_sl  [NE];
    bit s_wb  [NE];

    function automatic bit m_pend(int e);
        return m_act[e] && (m_long[e] || cyc <= m_due[e]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NE; e++) begin
                m_act[e] = 0; m_long[e] = 0; m_due[e] = 0;
            end
            m_err = 0;
        end else begin
            for (int e = 0; e < NE; e++) begin
                s_set[e] = 0; s_sl[e] = 0; s_wb[e] = 0;
            end
            for (int l = 0; l < L; l++) begin
                int ei, wi;
                ei = -1; wi = -1;
                if (iv[l] && rd_we[l]) ei = int'(rd[l*5 +: 5]);
                else if (iv[l] && pred_we[l] && rd[l*5 +: 2] != 2'd3) ei = NR + int'(rd[l*5 +: 2]);
                if (ei >= 0) begin
                    s_set[ei] = 1;
                    if (lng[l]) s_sl[ei] = 1;
                end
                if (wv[l]) begin
                    if (!wpred[l]) wi = int'(wrd[l*5 +: 5]);
                    else if (wrd[l*5 +: 2] != 2'd3) wi = NR + int'(wrd[l*5 +: 2]);
                end
                if (wi >= 0) s_wb[wi] = 1;
            end
            m_err = 0;
            if (flush) begin
                for (int e = 0; e < NE; e++) m_act[e] = 0;
            end else begin
                for (int e = 0; e < NE; e++) begin
                    if (s_wb[e] && !s_set[e] && !(m_pend(e) && m_long[e])) m_err = 1;
                end
                for (int e = 0; e < NE; e++) begin
                    if (s_set[e]) begin
                        m_act[e] = 1; m_long[e] = s_sl[e]; m_due[e] = cyc + LAT;
                    end else if (s_wb[e] && m_pend(e) && m_long[e]) begin
                        m_act[e] = 0;
                    end else if (!m_pend(e)) begin
                        m_act[e] = 0;
                    end
                end
            end
        end
        cyc++;
    end

    function automatic logic [NR-1:0] exp_reg();
        logic [NR-1:0] v;
        for (int e = 0; e < NR; e++) v[e] = m_pend(e);
        return v;
    endfunction

    function automatic logic [NP-1:0] exp_pred();
        logic [NP-1:0] v;
        for (int p = 0; p < NP; p++) v[p] = m_pend(NR + p);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [NR-1:0] er;
        logic [NP-1:0] ep;
        @(negedge clk);
        er = exp_reg();
        ep = exp_pred();
        chk("model_reg_sb", reg_sb, er);
        chk("model_pred_sb", {29'b0, pred_sb}, {29'b0, ep});
        chk("model_busy", {31'b0, busy}, {31'b0, (|er) || (|ep)});
        chk("model_err", {31'b0, err}, {31'b0, m_err});
    endtask

    task automatic clr_in();
        iv = '0; rd = '0; rd_we = '0; pred_we = '0; lng = '0;
        wv = '0; wrd = '0; wpred = '0; flush = 1'b0;
    endtask

    task automatic issue(input int l, input int r, input bit rw, input bit pw, input bit lg);
        iv[l] = 1'b1; rd[l*5 +: 5] = 5'(r); rd_we[l] = rw; pred_we[l] = pw; lng[l] = lg;
    endtask

    task automatic wback(input int l, input int r, input bit ip);
        wv[l] = 1'b1; wrd[l*5 +: 5] = 5'(r); wpred[l] = ip;
    endtask

    task automatic rand_in();
        for (int l = 0; l < L; l++) begin
            iv[l]      = ($urandom_range(0, 2) == 0);
            rd[l*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rd_we[l]   = ($urandom_range(0, 2) != 0);
            pred_we[l] = ($urandom_range(0, 1) == 0);
            lng[l]     = ($urandom_range(0, 1) == 0);
            wv[l]      = ($urandom_range(0, 3) == 0);
            wrd[l*5 +: 5] = 5'($urandom_range(0, 7));
            wpred[l]   = ($urandom_range(0, 4) == 0);
        end
        flush = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        // Reset with random inputs, then release.
        for (int i = 0; i < 3; i++) begin
            rand_in();
            tick();
            chk("rst_reg", reg_sb, 32'h0);
            chk("rst_busy", {31'b0, busy}, 32'h0);
            chk("rst_err", {31'b0, err}, 32'h0);
        end
        rst = 1'b0;
        clr_in();
        tick();
        tick();
        chk("post_rst_reg", reg_sb, 32'h0);
        chk("post_rst_pred", {29'b0, pred_sb}, 32'h0);

        // Short register producer: two cycles pending.
        issue(0, 5, 1, 0, 0);
        tick(); clr_in();
        chk("short_r5_c1", reg_sb, 32'h0000_0020);
        chk("short_busy_c1", {31'b0, busy}, 32'h1);
        tick();
        chk("short_r5_c2", reg_sb, 32'h0000_0020);
        tick();
        chk("short_r5_c3", reg_sb, 32'h0);
        chk("short_busy_c3", {31'b0, busy}, 32'h0);

        // Long producer held until writeback.
        issue(2, 7, 1, 0, 1);
        tick(); clr_in();
        for (int i = 0; i < 9; i++) begin
            chk("long_r7_hold", reg_sb, 32'h0000_0080);
            tick();
        end
        chk("long_r7_hold", reg_sb, 32'h0000_0080);
        wback(1, 7, 0);
        tick(); clr_in();
        chk("long_r7_wb", reg_sb, 32'h0);
        chk("long_r7_noerr", {31'b0, err}, 32'h0);

        // Predicate producers; index 3 ignored.
        issue(3, 1, 0, 1, 0);
        tick(); clr_in();
        chk("pred1_c1", {29'b0, pred_sb}, 32'h2);
        tick();
        chk("pred1_c2", {29'b0, pred_sb}, 32'h2);
        issue(3, 3, 0, 1, 0);
        tick(); clr_in();
        chk("pred3_ignored", {29'b0, pred_sb}, 32'h0);
        tick();
        chk("pred3_busy", {31'b0, busy}, 32'h0);

        // Flush beats issue in the same cycle.
        issue(0, 4, 1, 0, 1);
        tick(); clr_in();
        chk("flush_r4_set", reg_sb, 32'h0000_0010);
        flush = 1'b1;
        issue(1, 9, 1, 0, 1);
        tick(); clr_in();
        chk("flush_reg", reg_sb, 32'h0);
        chk("flush_busy", {31'b0, busy}, 32'h0);

        // Stray writeback errors; writeback with issue does not.
        wback(0, 12, 0);
        tick(); clr_in();
        chk("stray_wb_err", {31'b0, err}, 32'h1);
        chk("stray_wb_r12", reg_sb, 32'h0);
        tick();
        chk("stray_wb_err_drop", {31'b0, err}, 32'h0);
        issue(0, 12, 1, 0, 1);
        wback(0, 12, 0);
        tick(); clr_in();
        chk("wb_issue_r12", reg_sb, 32'h0000_1000);
        chk("wb_issue_noerr", {31'b0, err}, 32'h0);
        wback(2, 12, 0);
        wback(3, 12, 0);
        tick(); clr_in();
        chk("dual_wb_clear", reg_sb, 32'h0);
        chk("dual_wb_noerr", {31'b0, err}, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        clr_in();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
